// File: rtl/mod_plpinfo_pkg.sv
// plpinfo_pkg: register offsets, CAPS field positions and access decode
// shared by the board-identification peripheral and its tick sub-block.
package plpinfo_pkg;

  localparam logic [31:0] OFS_ID      = 32'h0000_0000;
  localparam logic [31:0] OFS_FREQ    = 32'h0000_0004;
  localparam logic [31:0] OFS_CYCLO   = 32'h0000_0008;
  localparam logic [31:0] OFS_CYCHI   = 32'h0000_000C;
  localparam logic [31:0] OFS_MSEC    = 32'h0000_0010;
  localparam logic [31:0] OFS_CAPS    = 32'h0000_0014;
  localparam logic [31:0] OFS_SCRATCH = 32'h0000_0020;

  // CAPS layout: {16'b0, scratch_count[7:0], 7'b0, cycle_en}
  localparam int CAPS_CYCLE_EN_BIT = 0;
  localparam int CAPS_SCRATCH_LSB  = 8;
  localparam int CAPS_SCRATCH_W    = 8;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_e;

  // drw = 2'b11 counts as a write only; a read needs exactly 2'b10.
  function automatic acc_e decode_acc(input logic de, input logic [1:0] drw);
    if (!de)               return ACC_NONE;
    else if (drw[0])       return ACC_WR;
    else if (drw == 2'b10) return ACC_RD;
    else                   return ACC_NONE;
  endfunction

endpackage

// File: rtl/mod_plpinfo_tick.sv
// mod_plpinfo_tick: millisecond prescaler and 32-bit MSEC counter.
// A load writes MSEC and restarts the prescaler; it wins over a same-cycle tick.
module mod_plpinfo_tick #(
  parameter int TICK_DIV = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] msec
);

  localparam int            PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          term;

  assign term = (presc == TC);

  // prescaler counts 0..TICK_DIV-1; terminal count bumps MSEC
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
      msec  <= '0;
    end else if (load) begin
      presc <= '0;
      msec  <= load_val;
    end else if (term) begin
      presc <= '0;
      msec  <= msec + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/mod_plpinfo.sv
// mod_plpinfo: board-identification peripheral on the PLP data bus.
// ID/FREQ/CAPS constants, 64-bit cycle counter with coherent high-word
// snapshot, millisecond uptime and SCRATCH_COUNT scratch words.
// Optional macro PLPINFO_CYCLE_EN builds the cycle counter and snapshot;
// without it CYCLO/CYCHI read 0 and CYCLO writes are ignored.
module mod_plpinfo
  import plpinfo_pkg::*;
#(
  parameter logic [31:0] CPU_ID        = 32'h0000_0300,
  parameter logic [31:0] BOARD_FREQ    = 32'h017d_7840,
  parameter int          TICK_DIV      = 25000,
  parameter int          SCRATCH_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ie,
  input  logic [31:0] iaddr,
  input  logic        de,
  input  logic [31:0] daddr,
  input  logic [1:0]  drw,
  input  logic [31:0] din,
  output logic [31:0] iout,
  output logic [31:0] dout
);

  acc_e        acc;
  logic        rd, wr;
  logic [31:0] msec;
  logic [31:0] cyc_lo;
  logic [31:0] snap_hi;
  logic [31:0] caps;
  logic [31:0] scr_rd;
  logic        cycle_en;
  logic        unused_ok;

  logic [SCRATCH_COUNT-1:0][31:0] scr;
  logic [SCRATCH_COUNT-1:0]       scr_hit;

  assign acc  = decode_acc(de, drw);
  assign rd   = (acc == ACC_RD);
  assign wr   = (acc == ACC_WR);
  assign iout = '0;

  // instruction side is not decoded by this block
  assign unused_ok = ^{ie, iaddr};

  mod_plpinfo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (wr && (daddr == OFS_MSEC)),
    .load_val (din),
    .msec     (msec)
  );

`ifdef PLPINFO_CYCLE_EN
  logic [63:0] cyc;
  logic [31:0] snap;

  // free-running cycle counter; a CYCLO read latches the high half that
  // pairs with the low half being returned this cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc  <= '0;
      snap <= '0;
    end else begin
      if (wr && (daddr == OFS_CYCLO)) cyc <= '0;
      else                            cyc <= cyc + 64'd1;
      if (rd && (daddr == OFS_CYCLO)) snap <= cyc[63:32];
    end
  end

  assign cyc_lo   = cyc[31:0];
  assign snap_hi  = snap;
  assign cycle_en = 1'b1;
`else
  assign cyc_lo   = '0;
  assign snap_hi  = '0;
  assign cycle_en = 1'b0;
`endif

  assign caps = {16'b0, CAPS_SCRATCH_W'(SCRATCH_COUNT), 7'b0, cycle_en};

  // full-address match per scratch word
  for (genvar i = 0; i < SCRATCH_COUNT; i++) begin : g_hit
    assign scr_hit[i] = (daddr == (OFS_SCRATCH + 32'(4 * i)));
  end

  // scratch words: whole-word writes only
  always_ff @(posedge clk) begin
    if (!rst) begin
      scr <= '0;
    end else begin
      for (int i = 0; i < SCRATCH_COUNT; i++)
        if (wr && scr_hit[i]) scr[i] <= din;
    end
  end

  // combinational read mux; unmapped or non-read accesses return 0
  always_comb begin
    scr_rd = '0;
    for (int i = 0; i < SCRATCH_COUNT; i++)
      if (scr_hit[i]) scr_rd = scr[i];
    dout = '0;
    if (rd) begin
      case (daddr)
        OFS_ID:    dout = CPU_ID;
        OFS_FREQ:  dout = BOARD_FREQ;
        OFS_CYCLO: dout = cyc_lo;
        OFS_CYCHI: dout = snap_hi;
        OFS_MSEC:  dout = msec;
        OFS_CAPS:  dout = caps;
        default:   dout = scr_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_plpinfo.sv
// tb_mod_plpinfo: directed checks of mod_plpinfo with TICK_DIV=4,
// SCRATCH_COUNT=4; honours PLPINFO_CYCLE_EN the same way the RTL does.
module tb_mod_plpinfo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ie = 1'b0;
  logic        de = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] daddr = '0;
  logic [31:0] din = '0;
  logic [1:0]  drw = '0;
  logic [31:0] iout, dout;
  logic [31:0] v;
  logic [31:0] exp_v;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mod_plpinfo #(.TICK_DIV(4), .SCRATCH_COUNT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .ie    (ie),
    .iaddr (iaddr),
    .de    (de),
    .daddr (daddr),
    .drw   (drw),
    .din   (din),
    .iout  (iout),
    .dout  (dout)
  );

  // advance one cycle; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    de  = 1'b0;
    drw = 2'b00;
  endtask

  // present a read for the rest of this cycle and sample the comb result
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    de    = 1'b1;
    drw   = 2'b10;
    daddr = a;
    #1;
    d = dout;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    de    = 1'b1;
    drw   = 2'b01;
    daddr = a;
    din   = d;
    tick();
  endtask

  // leaves the bench in cycle 0 after reset release
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rd(32'h08, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL reset_cyclo: got %h want %h", v, 32'h0); end
    rd(32'h10, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL reset_msec: got %h want %h", v, 32'h0); end
    nvec++; if (iout !== 32'h0) begin nerr++; $display("FAIL reset_iout: got %h want 0", iout); end
    tick();
    rd(32'h00, v); nvec++; if (v !== 32'h0000_0300) begin nerr++; $display("FAIL id: got %h want %h", v, 32'h0000_0300); end
    rd(32'h04, v); nvec++; if (v !== 32'h017d_7840) begin nerr++; $display("FAIL freq: got %h want %h", v, 32'h017d_7840); end
`ifdef PLPINFO_CYCLE_EN
    exp_v = 32'h0000_0401;
`else
    exp_v = 32'h0000_0400;
`endif
    rd(32'h14, v); nvec++; if (v !== exp_v) begin nerr++; $display("FAIL caps: got %h want %h", v, exp_v); end
    tick();
    rd(32'h18, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL unmapped_18: got %h want 0", v); end
    rd(32'h20, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL reset_scr0: got %h want 0", v); end
    de = 1'b1; drw = 2'b11; daddr = 32'h0; #1;
    nvec++; if (dout !== 32'h0) begin nerr++; $display("FAIL drw11_no_read: got %h want 0", dout); end
    tick();
    de = 1'b0; drw = 2'b10; daddr = 32'h0; #1;
    nvec++; if (dout !== 32'h0) begin nerr++; $display("FAIL de0_no_read: got %h want 0", dout); end
    tick();
  endtask

  task automatic test_cycle();
`ifdef PLPINFO_CYCLE_EN
    wr(32'h08, 32'hDEAD_BEEF);
    rd(32'h08, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL cyclo_clear0: got %h want 0", v); end
    tick();
    rd(32'h08, v); nvec++; if (v !== 32'h1) begin nerr++; $display("FAIL cyclo_clear1: got %h want 1", v); end
    tick();
    force dut.cyc = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cyc;
    tick();
    rd(32'h08, v); nvec++; if (v !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL cyclo_pre_wrap: got %h want ffffffff", v); end
    tick();
    rd(32'h0C, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL cychi_coherent: got %h want 0", v); end
    rd(32'h08, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL cyclo_post_wrap: got %h want 0", v); end
    tick();
    rd(32'h0C, v); nvec++; if (v !== 32'h1) begin nerr++; $display("FAIL cychi_after_wrap: got %h want 1", v); end
    tick();
    wr(32'h08, 32'h0);
    rd(32'h0C, v); nvec++; if (v !== 32'h1) begin nerr++; $display("FAIL cychi_no_snap_on_wr: got %h want 1", v); end
    rd(32'h08, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL cyclo_after_wr: got %h want 0", v); end
    tick();
`else
    for (int c = 0; c < 3; c++) begin
      rd(32'h08, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL cyclo_disabled: got %h want 0", v); end
      rd(32'h0C, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL cychi_disabled: got %h want 0", v); end
      tick();
    end
    wr(32'h08, 32'h1234_5678);
    rd(32'h08, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL cyclo_wr_ignored: got %h want 0", v); end
    tick();
`endif
    nvec++; if (iout !== 32'h0) begin nerr++; $display("FAIL iout_cycle: got %h want 0", iout); end
  endtask

  task automatic test_msec();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      exp_v = (c == 4) ? 32'h1 : 32'h0;
      rd(32'h10, v); nvec++; if (v !== exp_v) begin nerr++; $display("FAIL msec_first_tick c=%0d: got %h want %h", c, v, exp_v); end
      tick();
    end
    wr(32'h10, 32'hFFFF_FFFF);
    for (int d = 0; d <= 4; d++) begin
      exp_v = (d == 4) ? 32'h0 : 32'hFFFF_FFFF;
      rd(32'h10, v); nvec++; if (v !== exp_v) begin nerr++; $display("FAIL msec_wrap d=%0d: got %h want %h", d, v, exp_v); end
      tick();
    end
    // now at prescaler 1; two more cycles reach the terminal count
    tick();
    tick();
    wr(32'h10, 32'h0000_0100);
    for (int e = 0; e <= 4; e++) begin
      exp_v = (e == 4) ? 32'h0000_0101 : 32'h0000_0100;
      rd(32'h10, v); nvec++; if (v !== exp_v) begin nerr++; $display("FAIL msec_load_vs_tc e=%0d: got %h want %h", e, v, exp_v); end
      tick();
    end
  endtask

  task automatic test_scratch();
    wr(32'h2C, 32'hA5A5_A5A5);
    wr(32'h40, 32'h0000_1234);
    wr(32'h20, 32'h0BAD_F00D);
    rd(32'h2C, v); nvec++; if (v !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL scr3: got %h want a5a5a5a5", v); end
    rd(32'h40, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL unmapped_40: got %h want 0", v); end
    rd(32'h20, v); nvec++; if (v !== 32'h0BAD_F00D) begin nerr++; $display("FAIL scr0: got %h want 0badf00d", v); end
    tick();
    rd(32'h24, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL scr1_untouched: got %h want 0", v); end
    rd(32'h2D, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL misaligned_2d: got %h want 0", v); end
    tick();
    // reset with a same-cycle write that must be discarded
    de = 1'b1; drw = 2'b01; daddr = 32'h2C; din = 32'h5555_5555;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rd(32'h2C, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL scr3_after_rst: got %h want 0", v); end
    rd(32'h20, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL scr0_after_rst: got %h want 0", v); end
    rd(32'h10, v); nvec++; if (v !== 32'h0) begin nerr++; $display("FAIL msec_after_rst: got %h want 0", v); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wr(32'h20 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      exp_v = 32'h1111_1111 * 32'(i + 1);
      rd(32'h20 + 32'(4 * i), v); nvec++; if (v !== exp_v) begin nerr++; $display("FAIL b2b_scr%0d: got %h want %h", i, v, exp_v); end
      tick();
    end
    nvec++; if (iout !== 32'h0) begin nerr++; $display("FAIL iout_end: got %h want 0", iout); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cycle();
    test_msec();
    test_scratch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
